rng_request_arbiter: RTL and testbench

RNG_REQUEST_ARBITER -- requirements
Module: rng_request_arbiter

---
 rtl/rng_pkg.sv | 25 ++
 rtl/rng_req_picker.sv | 44 ++++
 rtl/rng_request_arbiter.sv | 100 ++++++++++
 tb/tb_rng_request_arbiter.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rng_pkg.sv
// rtl/rng_pkg.sv - shared sizes, FSM state encoding and small helpers for rng_request_arbiter
package rng_pkg;
  localparam int NUM_REQ  = 4;
  localparam int MOD_W    = 4;
  localparam int SAMPLE_W = 8;
  localparam int IDX_W    = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REDUCE = 2'd1,
    DONE   = 2'd2
  } state_t;

  function automatic logic [NUM_REQ-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_REQ-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

  function automatic logic [MOD_W-1:0] mod_slice(input logic [NUM_REQ*MOD_W-1:0] mods,
                                                 input logic [IDX_W-1:0]         idx);
    return mods[idx*MOD_W +: MOD_W];
  endfunction
endpackage

// File: rtl/rng_req_picker.sv
// rtl/rng_req_picker.sv - requester selection; RNG_ARB_ROUND_ROBIN_EN picks round-robin,
// otherwise fixed priority with req_i[0] highest.
module rng_req_picker
  import rng_pkg::*;
(
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic               vld_o,
  output logic [IDX_W-1:0]   idx_o
);
  logic [IDX_W-1:0] cand;

`ifdef RNG_ARB_ROUND_ROBIN_EN
  // Scan from farthest to nearest so the requester closest to the pointer wins.
  always_comb begin
    vld_o = 1'b0;
    idx_o = '0;
    cand  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = ptr_i + IDX_W'(k);
      if (req_i[cand]) begin
        vld_o = 1'b1;
        idx_o = cand;
      end
    end
  end
`else
  logic unused_ptr;
  assign unused_ptr = ^ptr_i;

  always_comb begin
    vld_o = 1'b0;
    idx_o = '0;
    cand  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = IDX_W'(k);
      if (req_i[cand]) begin
        vld_o = 1'b1;
        idx_o = cand;
      end
    end
  end
`endif
endmodule

// File: rtl/rng_request_arbiter.sv
// rtl/rng_request_arbiter.sv - arbitrates four requesters and reduces an 8-bit LFSR sample modulo
// the winner's modulus by repeated subtraction; RNG_ARB_ROUND_ROBIN_EN enables round-robin pick.
module rng_request_arbiter
  import rng_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic [15:0]              rng_in,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*MOD_W-1:0] mod_in,
  output logic [NUM_REQ-1:0]       grant,
  output logic [MOD_W-1:0]         rnd_out,
  output logic                     valid,
  output logic                     busy
);
  state_t              state_q;
  logic [SAMPLE_W-1:0] acc_q;
  logic [SAMPLE_W-1:0] acc_d;
  logic [IDX_W-1:0]    idx_q;
  logic [MOD_W-1:0]    mod_q;
  logic [NUM_REQ-1:0]  grant_q;
  logic [MOD_W-1:0]    rnd_q;
  logic                valid_q;

  logic                pick_vld;
  logic [IDX_W-1:0]    pick_idx;
  logic [IDX_W-1:0]    rr_ptr;
  logic                reduce_exit;
  logic                unused_rng;

  assign unused_rng = ^rng_in[15:SAMPLE_W];

`ifdef RNG_ARB_ROUND_ROBIN_EN
  logic [IDX_W-1:0] rr_ptr_q;
  assign rr_ptr = rr_ptr_q;
`else
  assign rr_ptr = '0;
`endif

  rng_req_picker u_picker (
    .req_i (req),
    .ptr_i (rr_ptr),
    .vld_o (pick_vld),
    .idx_o (pick_idx)
  );

  assign acc_d = acc_q - SAMPLE_W'(mod_q);
  // A zero modulus would never leave REDUCE, so it exits at once with the raw sample nibble.
  assign reduce_exit = (mod_q == '0) || (acc_q < SAMPLE_W'(mod_q));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      idx_q    <= '0;
      mod_q    <= '0;
      grant_q  <= '0;
      rnd_q    <= '0;
      valid_q  <= 1'b0;
`ifdef RNG_ARB_ROUND_ROBIN_EN
      rr_ptr_q <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_vld) begin
            idx_q    <= pick_idx;
            mod_q    <= mod_slice(mod_in, pick_idx);
            acc_q    <= rng_in[SAMPLE_W-1:0];
            state_q  <= REDUCE;
`ifdef RNG_ARB_ROUND_ROBIN_EN
            rr_ptr_q <= pick_idx + IDX_W'(1);
`endif
          end
        end
        REDUCE: begin
          if (reduce_exit) begin
            rnd_q   <= acc_q[MOD_W-1:0];
            grant_q <= idx_onehot(idx_q);
            valid_q <= 1'b1;
            state_q <= DONE;
          end else begin
            acc_q   <= acc_d;
          end
        end
        DONE: begin
          grant_q <= '0;
          valid_q <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant   = grant_q;
  assign rnd_out = rnd_q;
  assign valid   = valid_q;
  assign busy    = (state_q != IDLE);
endmodule

// File: tb/tb_rng_request_arbiter.sv
// tb/tb_rng_request_arbiter.sv - scoreboard bench for rng_request_arbiter; expected order under
// contention depends on RNG_ARB_ROUND_ROBIN_EN.
module tb_rng_request_arbiter;
  logic        clk;
  logic        rst;
  logic [15:0] rng_in;
  logic [3:0]  req;
  logic [15:0] mod_in;
  logic [3:0]  grant;
  logic [3:0]  rnd_out;
  logic        valid;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [3:0] grant;
    logic [3:0] rnd;
    int         lat;
  } exp_t;

  exp_t sb_q[$];

  rng_request_arbiter dut (
    .clk     (clk),
    .rst     (rst),
    .rng_in  (rng_in),
    .req     (req),
    .mod_in  (mod_in),
    .grant   (grant),
    .rnd_out (rnd_out),
    .valid   (valid),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] model_rnd(input logic [7:0] s, input logic [3:0] m);
    int r;
    if (m == 4'd0) r = int'(s) % 16;
    else r = int'(s) % int'(m);
    return 4'(r);
  endfunction

  function automatic int model_lat(input logic [7:0] s, input logic [3:0] m);
    if (m == 4'd0) return 1;
    return int'(s) / int'(m) + 1;
  endfunction

  function automatic exp_t make_exp(input int idx, input logic [7:0] s, input logic [15:0] mods);
    exp_t e;
    logic [3:0] m;
    m       = mods[idx*4 +: 4];
    e.grant = 4'(1 << idx);
    e.rnd   = model_rnd(s, m);
    e.lat   = model_lat(s, m);
    return e;
  endfunction

  // Waits for valid; edges counts negedges consumed, busy_hi drops if busy was ever low meanwhile.
  task automatic wait_valid(input int budget, output int edges, output bit busy_hi, output bit hit);
    edges = 0; busy_hi = 1'b1; hit = 1'b0;
    while (edges < budget && !hit) begin
      @(negedge clk);
      edges++;
      if (valid) hit = 1'b1;
      else if (!busy) busy_hi = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '0; rng_in = '0; mod_in = '0;
    @(negedge clk);
    checks++; if (grant !== 4'b0) begin failures++; $display("FAIL reset_grant got=%b exp=0000", grant); end
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid); end
    checks++; if (rnd_out !== 4'h0) begin failures++; $display("FAIL reset_rnd got=%h exp=0", rnd_out); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    exp_t e; int edges; bit bh, hit;
    mod_in = {4'h9, 4'h3, 4'h2, 4'd6};
    rng_in = {8'($urandom), 8'h2B};
    req    = 4'b0001;
    sb_q.push_back(make_exp(0, 8'h2B, mod_in));
    wait_valid(400, edges, bh, hit);
    e = sb_q.pop_front();
    req = '0;
    checks++; if (!hit) begin failures++; $display("FAIL single_timeout edges=%0d", edges); end
    checks++; if (grant !== e.grant) begin failures++; $display("FAIL single_grant got=%b exp=%b", grant, e.grant); end
    checks++; if (rnd_out !== e.rnd) begin failures++; $display("FAIL single_rnd got=%h exp=%h", rnd_out, e.rnd); end
    checks++; if (edges - 1 !== e.lat) begin failures++; $display("FAIL single_latency got=%0d exp=%0d", edges - 1, e.lat); end
    @(negedge clk);
    checks++; if (valid !== 1'b0 || grant !== 4'b0) begin failures++; $display("FAIL single_pulse valid=%b grant=%b exp 0/0000", valid, grant); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_busy1 got=%b exp=0", busy); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_busy2 got=%b exp=0", busy); end
    checks++; if (rnd_out !== e.rnd) begin failures++; $display("FAIL single_hold got=%h exp=%h", rnd_out, e.rnd); end
  endtask

  task automatic test_mod_zero();
    exp_t e; int edges; bit bh, hit;
    mod_in = {4'h5, 4'd0, 4'h7, 4'h1};
    rng_in = {8'($urandom), 8'hA7};
    req    = 4'b0100;
    sb_q.push_back(make_exp(2, 8'hA7, mod_in));
    wait_valid(400, edges, bh, hit);
    e = sb_q.pop_front();
    req = '0;
    checks++; if (!hit) begin failures++; $display("FAIL modzero_timeout edges=%0d", edges); end
    checks++; if (grant !== e.grant) begin failures++; $display("FAIL modzero_grant got=%b exp=%b", grant, e.grant); end
    checks++; if (rnd_out !== e.rnd) begin failures++; $display("FAIL modzero_rnd got=%h exp=%h", rnd_out, e.rnd); end
    checks++; if (edges - 1 !== e.lat) begin failures++; $display("FAIL modzero_latency got=%0d exp=%0d", edges - 1, e.lat); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_worst_case();
    exp_t e; int edges; bit bh, hit;
    mod_in = {4'h2, 4'h3, 4'h4, 4'd1};
    rng_in = {8'($urandom), 8'hFF};
    req    = 4'b0001;
    sb_q.push_back(make_exp(0, 8'hFF, mod_in));
    wait_valid(400, edges, bh, hit);
    e = sb_q.pop_front();
    req = '0;
    checks++; if (!hit) begin failures++; $display("FAIL worst_timeout edges=%0d", edges); end
    checks++; if (rnd_out !== e.rnd) begin failures++; $display("FAIL worst_rnd got=%h exp=%h", rnd_out, e.rnd); end
    checks++; if (edges - 1 !== e.lat) begin failures++; $display("FAIL worst_latency got=%0d exp=%0d", edges - 1, e.lat); end
    checks++; if (bh !== 1'b1) begin failures++; $display("FAIL worst_busy got=%b exp=1", bh); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_random();
    exp_t e; int edges; bit bh, hit; int idx; logic [7:0] s;
    for (int n = 0; n < 6; n++) begin
      idx    = $urandom_range(0, 3);
      s      = 8'($urandom_range(0, 255));
      mod_in = 16'($urandom);
      rng_in = {8'($urandom), s};
      req    = 4'(1 << idx);
      sb_q.push_back(make_exp(idx, s, mod_in));
      wait_valid(400, edges, bh, hit);
      e = sb_q.pop_front();
      req = '0;
      checks++;
      if (!hit || grant !== e.grant || rnd_out !== e.rnd || edges - 1 !== e.lat) begin
        failures++;
        $display("FAIL random_%0d grant=%b/%b rnd=%h/%h lat=%0d/%0d (got/exp)", n, grant, e.grant, rnd_out, e.rnd, edges - 1, e.lat);
      end
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic test_contention();
    exp_t e; int edges; bit bh, hit;
    int order [5];
`ifdef RNG_ARB_ROUND_ROBIN_EN
    order = '{0, 1, 2, 3, 0};
`else
    order = '{0, 1, 0, 2, 3};
`endif
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mod_in = {4'd5, 4'd3, 4'd7, 4'd0};
    rng_in = {8'($urandom), 8'h3D};
    for (int k = 0; k < 5; k++) sb_q.push_back(make_exp(order[k], 8'h3D, mod_in));
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_valid(400, edges, bh, hit);
      e = sb_q.pop_front();
      req = req & ~grant;
      if (k == 1) req[0] = 1'b1;
      checks++;
      if (!hit || grant !== e.grant || rnd_out !== e.rnd) begin
        failures++;
        $display("FAIL contention_%0d grant=%b/%b rnd=%h/%h hit=%b (got/exp)", k, grant, e.grant, rnd_out, e.rnd, hit);
      end
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL contention_gap_%0d busy=%b exp=0", k, busy); end
    end
    req = '0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    exp_t e; int edges; bit bh, hit; int hits;
    mod_in = {4'h3, 4'h3, 4'h3, 4'd1};
    rng_in = {8'($urandom), 8'h80};
    req    = 4'b0001;
    repeat (11) @(negedge clk);
    req = '0;
    rst = 1'b1;
    #1;
    checks++;
    if (grant !== 4'b0 || valid !== 1'b0 || rnd_out !== 4'h0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL midreset_outputs grant=%b valid=%b rnd=%h busy=%b exp all zero", grant, valid, rnd_out, busy);
    end
    @(negedge clk);
    rst  = 1'b0;
    hits = 0;
    repeat (300) begin
      @(negedge clk);
      if (valid || grant != 4'b0) hits++;
    end
    checks++; if (hits !== 0) begin failures++; $display("FAIL midreset_no_grant got=%0d exp=0", hits); end
    mod_in = {4'h3, 4'h3, 4'h3, 4'd6};
    rng_in = {8'($urandom), 8'h2B};
    req    = 4'b0001;
    sb_q.push_back(make_exp(0, 8'h2B, mod_in));
    wait_valid(400, edges, bh, hit);
    e = sb_q.pop_front();
    req = '0;
    checks++;
    if (!hit || grant !== e.grant || rnd_out !== e.rnd || edges - 1 !== e.lat) begin
      failures++;
      $display("FAIL midreset_after grant=%b/%b rnd=%h/%h lat=%0d/%0d (got/exp)", grant, e.grant, rnd_out, e.rnd, edges - 1, e.lat);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_withdrawn();
    exp_t e0, e1; int edges; bit bh, hit;
    mod_in = {4'h7, 4'd2, 4'd3, 4'h5};
    rng_in = {8'($urandom), 8'h15};
    req    = 4'b0100;
    sb_q.push_back(make_exp(2, 8'h15, mod_in));
    repeat (3) @(negedge clk);
    req[2] = 1'b0;
    repeat (2) @(negedge clk);
    req[1] = 1'b1;
    wait_valid(400, edges, bh, hit);
    e0 = sb_q.pop_front();
    checks++;
    if (!hit || grant !== e0.grant || rnd_out !== e0.rnd || edges + 4 !== e0.lat) begin
      failures++;
      $display("FAIL withdrawn_grant grant=%b/%b rnd=%h/%h lat=%0d/%0d (got/exp)", grant, e0.grant, rnd_out, e0.rnd, edges + 4, e0.lat);
    end
    rng_in = {8'($urandom), 8'h1D};
    sb_q.push_back(make_exp(1, 8'h1D, mod_in));
    wait_valid(400, edges, bh, hit);
    e1 = sb_q.pop_front();
    req = '0;
    checks++;
    if (!hit || grant !== e1.grant || rnd_out !== e1.rnd || edges !== e1.lat + 2) begin
      failures++;
      $display("FAIL withdrawn_next grant=%b/%b rnd=%h/%h edges=%0d/%0d (got/exp)", grant, e1.grant, rnd_out, e1.rnd, edges, e1.lat + 2);
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_mod_zero();
    test_worst_case();
    test_random();
    test_contention();
    test_reset_mid();
    test_withdrawn();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
